// File: rtl/pipe_rbcla_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_rbcla_adder
//  Purpose  : Pipelined ripple-block carry look-ahead adder/subtractor with
//             valid/ready handshake and global-stall backpressure.
//  Revision : 1.0 - initial release
// ============================================================================
module pipe_rbcla_adder #(
  parameter int WIDTH         = 20,
  parameter int BLOCK         = 4,
  parameter int BLK_PER_STAGE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ivalid,
  output logic             iready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             cin,
  input  logic             sub,
  output logic             ovalid,
  input  logic             oready,
  output logic [WIDTH:0]   s,
  output logic             ovf
);

  localparam int NBLK = (WIDTH + BLOCK - 1) / BLOCK;
  localparam int LAT  = (NBLK + BLK_PER_STAGE - 1) / BLK_PER_STAGE;

  logic [WIDTH-1:0] r_x    [LAT];
  logic [WIDTH-1:0] r_y    [LAT];
  logic [WIDTH-1:0] r_sum  [LAT];
  logic             r_c    [LAT];
  logic             r_cmsb [LAT];
  logic             r_v    [LAT];

  logic w_adv;

  assign w_adv  = ~r_v[LAT-1] | oready;
  assign iready = w_adv;
  assign ovalid = r_v[LAT-1];
  assign s      = {r_c[LAT-1], r_sum[LAT-1]};
  assign ovf    = r_cmsb[LAT-1] ^ r_c[LAT-1];

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    localparam int FB = k * BLK_PER_STAGE;
    localparam int LB = ((k + 1) * BLK_PER_STAGE < NBLK) ? (k + 1) * BLK_PER_STAGE : NBLK;

    logic [WIDTH-1:0] w_ix;
    logic [WIDTH-1:0] w_iy;
    logic [WIDTH-1:0] w_isum;
    logic             w_ic;
    logic             w_iv;
    logic [WIDTH-1:0] w_sum;
    logic             w_cmsb;
    logic             w_c;
    logic             w_cb;
    logic             w_acc;
    logic             w_pr;
    logic             w_cj;

    if (k == 0) begin : g_head
      // Operand conditioning happens once here; later stages see y' directly.
      assign w_ix   = x;
      assign w_iy   = y ^ {WIDTH{sub}};
      assign w_isum = '0;
      assign w_ic   = sub | cin;
      assign w_iv   = ivalid;
    end else begin : g_body
      assign w_ix   = r_x[k-1];
      assign w_iy   = r_y[k-1];
      assign w_isum = r_sum[k-1];
      assign w_ic   = r_c[k-1];
      assign w_iv   = r_v[k-1];
    end

    always_comb begin
      w_sum  = w_isum;
      w_cmsb = 1'b0;
      w_c    = w_ic;
      w_cb   = 1'b0;
      w_acc  = 1'b0;
      w_pr   = 1'b1;
      w_cj   = 1'b0;
      for (int b = FB; b < LB; b++) begin
        w_cb = w_c;
        for (int j = 0; j <= BLOCK; j++) begin
          // Flat sum-of-products carry into bit j of the block; bits past the
          // top of a short last block are skipped so j==BLOCK is its true cout.
          w_acc = 1'b0;
          w_pr  = 1'b1;
          for (int m = j - 1; m >= 0; m--) begin
            if (b * BLOCK + m < WIDTH) begin
              w_acc = w_acc | (w_pr & w_ix[b*BLOCK+m] & w_iy[b*BLOCK+m]);
              w_pr  = w_pr & (w_ix[b*BLOCK+m] ^ w_iy[b*BLOCK+m]);
            end
          end
          w_cj = w_acc | (w_pr & w_cb);
          if (j < BLOCK && b * BLOCK + j < WIDTH) begin
            w_sum[b*BLOCK+j] = w_ix[b*BLOCK+j] ^ w_iy[b*BLOCK+j] ^ w_cj;
            if (b * BLOCK + j == WIDTH - 1) begin
              w_cmsb = w_cj;
            end
          end
          if (j == BLOCK) begin
            w_c = w_cj;
          end
        end
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_v[k]    <= 1'b0;
        r_x[k]    <= '0;
        r_y[k]    <= '0;
        r_sum[k]  <= '0;
        r_c[k]    <= 1'b0;
        r_cmsb[k] <= 1'b0;
      end else if (w_adv) begin
        r_v[k] <= w_iv;
        if (w_iv) begin
          r_x[k]    <= w_ix;
          r_y[k]    <= w_iy;
          r_sum[k]  <= w_sum;
          r_c[k]    <= w_c;
          r_cmsb[k] <= w_cmsb;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_rbcla_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_rbcla_adder
//  Purpose  : Directed vector bench for pipe_rbcla_adder, default and swept
//             parameter sets.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_rbcla_adder;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        ivalid, iready, cin, sub, ovalid, oready, ovf;
  logic [19:0] x, y;
  logic [20:0] s;

  always #5 clk = ~clk;

  pipe_rbcla_adder dut (
    .clk(clk), .rst(rst), .ivalid(ivalid), .iready(iready), .x(x), .y(y),
    .cin(cin), .sub(sub), .ovalid(ovalid), .oready(oready), .s(s), .ovf(ovf)
  );

  // Parameter sweep instances share one stimulus bus
  logic [31:0] sw_x, sw_y;
  logic        sw_cin, sw_sub, sw_iv;
  logic        a_ir, a_ov, a_ovf, b_ir, b_ov, b_ovf, c_ir, c_ov, c_ovf;
  logic [1:0]  a_s;
  logic [7:0]  b_s;
  logic [32:0] c_s;

  pipe_rbcla_adder #(.WIDTH(1), .BLOCK(1), .BLK_PER_STAGE(1)) dut_a (
    .clk(clk), .rst(rst), .ivalid(sw_iv), .iready(a_ir), .x(sw_x[0:0]), .y(sw_y[0:0]),
    .cin(sw_cin), .sub(sw_sub), .ovalid(a_ov), .oready(1'b1), .s(a_s), .ovf(a_ovf)
  );
  pipe_rbcla_adder #(.WIDTH(7), .BLOCK(3), .BLK_PER_STAGE(1)) dut_b (
    .clk(clk), .rst(rst), .ivalid(sw_iv), .iready(b_ir), .x(sw_x[6:0]), .y(sw_y[6:0]),
    .cin(sw_cin), .sub(sw_sub), .ovalid(b_ov), .oready(1'b1), .s(b_s), .ovf(b_ovf)
  );
  pipe_rbcla_adder #(.WIDTH(32), .BLOCK(4), .BLK_PER_STAGE(8)) dut_c (
    .clk(clk), .rst(rst), .ivalid(sw_iv), .iready(c_ir), .x(sw_x), .y(sw_y),
    .cin(sw_cin), .sub(sw_sub), .ovalid(c_ov), .oready(1'b1), .s(c_s), .ovf(c_ovf)
  );

  typedef struct {
    logic [19:0] x;
    logic [19:0] y;
    logic        cin;
    logic        sub;
    logic [20:0] es;
    logic        eo;
  } vec_t;

  typedef struct {
    int idx;
    int acc;
    bit lat;
  } exp_t;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic        cin;
    logic        sub;
  } sw_t;

  vec_t vec [12];
  sw_t  swv [8];
  exp_t q [$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   bp_done;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, want, $time);
    end
  endtask

  // Output scoreboard: every handshake must match the next accepted vector
  always @(negedge clk) begin
    exp_t e;
    if (!rst && ovalid && oready) begin
      if (q.size() == 0) begin
        chk("stray_out", ovalid, 1'b0);
      end else begin
        e = q.pop_front();
        chk("sum", s, vec[e.idx].es);
        chk("ovf", ovf, vec[e.idx].eo);
        if (e.lat) chk("latency", cyc - e.acc, LAT - 1);
      end
    end
  end

  task automatic send(input int i, input bit lat);
    int n = 0;
    exp_t e;
    @(negedge clk);
    x = vec[i].x; y = vec[i].y; cin = vec[i].cin; sub = vec[i].sub; ivalid = 1'b1;
    while (!iready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!iready) begin
      chk("iready_wait", iready, 1'b1);
    end else begin
      e.idx = i; e.acc = cyc + 1; e.lat = lat;
      q.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
  endtask

  function automatic logic [33:0] refm(input int w, input logic [31:0] a, input logic [31:0] b,
                                       input logic c, input logic sb);
    logic [63:0] m, aa, bb, sum;
    logic        o;
    m   = (64'd1 << w) - 64'd1;
    aa  = {32'd0, a} & m;
    bb  = (sb ? ~{32'd0, b} : {32'd0, b}) & m;
    sum = aa + bb + {63'd0, sb | c};
    o   = (aa[w-1] == bb[w-1]) && (sum[w-1] != aa[w-1]);
    return {o, sum[32:0]};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, la, lb, lc;
    logic [33:0] ra, rb, rc;
    logic [1:0]  sa;
    logic [7:0]  sb8;
    logic [32:0] sc;
    logic        oa, ob, oc;

    vec[0]  = '{20'hFFFFF, 20'h00001, 1'b0, 1'b0, 21'h100000, 1'b0};
    vec[1]  = '{20'h7FFFF, 20'h00001, 1'b0, 1'b0, 21'h080000, 1'b1};
    vec[2]  = '{20'h00005, 20'h00007, 1'b0, 1'b1, 21'h0FFFFE, 1'b0};
    vec[3]  = '{20'h00000, 20'h00000, 1'b1, 1'b0, 21'h000001, 1'b0};
    vec[4]  = '{20'h12345, 20'h54321, 1'b0, 1'b0, 21'h066666, 1'b0};
    vec[5]  = '{20'h80000, 20'h80000, 1'b0, 1'b0, 21'h100000, 1'b1};
    vec[6]  = '{20'hABCDE, 20'h11111, 1'b1, 1'b0, 21'h0BCDF0, 1'b0};
    vec[7]  = '{20'h00010, 20'h00001, 1'b0, 1'b1, 21'h10000F, 1'b0};
    vec[8]  = '{20'h80000, 20'h00001, 1'b0, 1'b1, 21'h17FFFF, 1'b1};
    vec[9]  = '{20'hFFFFF, 20'hFFFFF, 1'b0, 1'b1, 21'h100000, 1'b0};
    vec[10] = '{20'h0F0F0, 20'h0F0F0, 1'b1, 1'b0, 21'h01E1E1, 1'b0};
    vec[11] = '{20'h00003, 20'h00003, 1'b1, 1'b1, 21'h100000, 1'b0};

    swv[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0};
    swv[1] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0};
    swv[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0};
    swv[3] = '{32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0};
    swv[4] = '{32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b1};
    for (int i = 5; i < 8; i++)
      swv[i] = '{$urandom, $urandom, 1'($urandom_range(1)), 1'($urandom_range(1))};

    rst = 1'b1; ivalid = 1'b0; oready = 1'b1; x = '0; y = '0; cin = 1'b0; sub = 1'b0;
    sw_x = '0; sw_y = '0; sw_cin = 1'b0; sw_sub = 1'b0; sw_iv = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ovalid", ovalid, 1'b0);
    chk("rst_s", s, 21'h0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_iready", iready, 1'b1);
    @(posedge clk); #1 rst = 1'b0;

    // Back-to-back stream, no backpressure
    for (int i = 0; i < 12; i++) send(i, 1'b1);
    @(negedge clk); ivalid = 1'b0;
    drain();

    // Backpressure: output stalled while the source keeps offering
    @(posedge clk); #1 oready = 1'b0;
    bp_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 5; i++) send(i, 1'b0);
        @(negedge clk); ivalid = 1'b0;
        bp_done = 1'b1;
      end
    join_none
    n = 0;
    @(negedge clk);
    while (!ovalid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_ovalid_rise", ovalid, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("bp_hold_valid", ovalid, 1'b1);
      chk("bp_iready_low", iready, 1'b0);
      chk("bp_hold_s", s, vec[0].es);
      chk("bp_hold_ovf", ovf, vec[0].eo);
    end
    @(posedge clk); #1 oready = 1'b1;
    n = 0;
    while (!bp_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("bp_driver_done", bp_done, 1'b1);
    drain();

    // Asynchronous reset with two results in flight
    send(4, 1'b1);
    send(5, 1'b1);
    @(negedge clk); ivalid = 1'b0;
    #2 rst = 1'b1;
    q.delete();
    #1;
    chk("midrst_ovalid", ovalid, 1'b0);
    chk("midrst_s", s, 21'h0);
    chk("midrst_ovf", ovf, 1'b0);
    @(posedge clk); #1 rst = 1'b0;
    repeat (6) @(negedge clk);
    send(6, 1'b1);
    @(negedge clk); ivalid = 1'b0;
    drain();

    // Parameter sweep: one transaction at a time, latency and value per instance
    for (int v = 0; v < 8; v++) begin
      @(negedge clk);
      sw_x = swv[v].x; sw_y = swv[v].y; sw_cin = swv[v].cin; sw_sub = swv[v].sub; sw_iv = 1'b1;
      @(negedge clk);
      sw_iv = 1'b0;
      la = -1; lb = -1; lc = -1;
      sa = '0; sb8 = '0; sc = '0; oa = 1'b0; ob = 1'b0; oc = 1'b0;
      for (int k = 0; k < 5; k++) begin
        if (a_ov && la < 0) begin la = k; sa = a_s; oa = a_ovf; end
        if (b_ov && lb < 0) begin lb = k; sb8 = b_s; ob = b_ovf; end
        if (c_ov && lc < 0) begin lc = k; sc = c_s; oc = c_ovf; end
        @(negedge clk);
      end
      ra = refm(1, swv[v].x, swv[v].y, swv[v].cin, swv[v].sub);
      rb = refm(7, swv[v].x, swv[v].y, swv[v].cin, swv[v].sub);
      rc = refm(32, swv[v].x, swv[v].y, swv[v].cin, swv[v].sub);
      chk("sw_a_lat", la, 0);
      chk("sw_a_s", sa, ra[1:0]);
      chk("sw_a_ovf", oa, ra[33]);
      chk("sw_b_lat", lb, 2);
      chk("sw_b_s", sb8, rb[7:0]);
      chk("sw_b_ovf", ob, rb[33]);
      chk("sw_c_lat", lc, 0);
      chk("sw_c_s", sc, rc[32:0]);
      chk("sw_c_ovf", oc, rc[33]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_rbcla_adder.md
Name: pipe_rbcla_adder

Overview:
- Parametrised, pipelined ripple-block carry look-ahead adder/subtractor.
- The operand width is split into BLOCK-bit look-ahead blocks. Blocks form a carry ripple chain, and BLK_PER_STAGE blocks are resolved per pipeline stage.
- Carries a valid/ready handshake on both sides with full backpressure.
- Sits in the datapath library as the registered successor of the combinational ripple-block CLA family; used where the combinational adder misses timing.

Parameters:
- WIDTH, 20: operand width in bits. Minimum 1.
- BLOCK, 4: bits per carry look-ahead block. Must satisfy 1 <= BLOCK <= WIDTH.
- BLK_PER_STAGE, 2: look-ahead blocks resolved per pipeline stage. Minimum 1.
- Derived NBLK = ceil(WIDTH/BLOCK). The last block may be narrower than BLOCK.
- Derived LAT = ceil(NBLK/BLK_PER_STAGE): pipeline depth in register stages.

Ports:
- CLK, input, 1: clock, rising edge.
- RST, input, 1: asynchronous, active-high reset.
- IVALID, input, 1: input operands valid.
- IREADY, output, 1: block accepts the input this cycle.
- X, input, WIDTH: operand 1, unsigned or two's complement.
- Y, input, WIDTH: operand 2.
- CIN, input, 1: carry-in. Ignored when SUB=1.
- SUB, input, 1: 1 selects S = X - Y (Y inverted, carry-in forced to 1).
- OVALID, output, 1: result valid.
- OREADY, input, 1: downstream accepts the result.
- S, output, WIDTH+1: result. S[WIDTH] is the carry-out. When SUB=1, S[WIDTH] = 1 means no borrow.
- OVF, output, 1: two's-complement signed overflow of the WIDTH-bit result.

Behaviour:
- Reset (async assert): all stage valid bits clear, OVALID=0, S=0, OVF=0, and all internal carry, operand and partial-sum registers go to 0. Deassertion is synchronous to CLK by integration; the block needs no special handling.
- Datapath:
  - Per bit: g = x & y', p = x ^ y', where y' = Y ^ {WIDTH{SUB}}.
  - Per block: group G/P and internal carries are computed by full look-ahead, as in a 4-bit CLA unit generalised to BLOCK bits.
  - Block carry-in = previous block's carry-out (ripple between blocks).
  - Block 0 carry-in = SUB ? 1 : CIN.
- Stage k (0..LAT-1) resolves blocks k*BLK_PER_STAGE through min((k+1)*BLK_PER_STAGE, NBLK)-1. Each stage registers:
  - the carry into the next stage,
  - sum bits produced so far,
  - still-unprocessed upper operand bits (already conditioned by SUB),
  - the stage valid bit.
- Lower sum bits are delay-matched so the whole S word emerges aligned.
- Output:
  - S[WIDTH] = carry out of the top block.
  - OVF = carry into the MSB XOR carry out of the MSB, registered with S.
- Latency: exactly LAT cycles from an accepted input (IVALID & IREADY at edge t) to OVALID=1 after edge t+LAT-1, when there is no backpressure. Throughput is one result per cycle.
- Handshake:
  - Global stall. advance = ~OVALID | OREADY. IREADY = advance, combinational from OVALID/OREADY only, never from IVALID.
  - When advance=1, every stage shifts one step.
  - A stage whose source is invalid loads valid=0; its data registers may hold.
  - When advance=0, all stage registers hold.
  - S and OVF are stable while OVALID & ~OREADY.
- Bubbles: an IVALID=0 cycle with advance=1 inserts a bubble. Bubbles propagate and never produce OVALID.
- Simultaneous events:
  - Accept and emit in the same cycle is allowed.
  - OREADY=1 while OVALID=0 has no effect.
  - IVALID held while IREADY=0: operands are not sampled. The source must hold them (AXI-style).
- Reset mid-operation: all in-flight results are discarded with no partial output. The first post-reset result has latency LAT.
- Boundaries:
  - LAT=1 gives a single registered combinational adder.
  - If BLK_PER_STAGE >= NBLK, then LAT = 1.
  - WIDTH not a multiple of BLOCK: the top block has WIDTH mod BLOCK bits, and carry-out is taken from its true MSB.
  - Wrap-around: the sum modulo 2^WIDTH is in S[WIDTH-1:0].

Test Plan:
- Defaults (LAT=3), X=20'hFFFFF, Y=20'h00001, CIN=0, SUB=0, OREADY=1 -> after 3 cycles S=21'h100000, OVF=0. Full-length carry ripple across all 5 blocks.
- X=20'h7FFFF, Y=20'h00001, SUB=0 -> S=21'h080000, OVF=1. Then X=20'h00005, Y=20'h00007, SUB=1 -> S=21'h0FFFFE, OVF=0.
- Back-to-back stream of 8 random pairs with OREADY=1 -> 8 consecutive OVALID cycles, in order, each matching X+Y+CIN. Include CIN=1 with X=Y=0 -> S=1.
- OREADY held 0 for 5 cycles with IVALID=1 constantly -> OVALID rises, S/OVF frozen. IREADY=0 once the pipe is full (3 held results). Releasing OREADY drains all results in order with no loss or duplicate.
- Assert RST for 1 cycle with 2 transactions in flight -> OVALID=0 and S=0 immediately (async). No stale result ever appears. A new input yields OVALID exactly 3 cycles later.
- Sweep (WIDTH,BLOCK,BLK_PER_STAGE) = (1,1,1), (7,3,1), (32,4,8) with random operands including all-ones and 0 -> latency equals LAT (1, 3, 1) and S matches the reference sum.
